id_stage_p: RTL and testbench

Parametrised instruction-decode stage for the 19-bit accelerator-SoC pipeline, successor to the fixed-width decoder. It decodes fetched instructions into an ID/EX pipeline register guarded by a valid/ready handshake, owns the register file with write-back bypass, and detects load-use hazards. It replaces static branch prediction with a PC-indexed table of 2-bit saturating counters trained by the execute stage.

---
 rtl/id_pkg.sv | 40 ++++
 rtl/id_bht.sv | 35 +++
 rtl/id_stage_p.sv | 156 +++++++++++++++
 tb/tb_id_stage_p.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes, the
// predictor reset value and the control half of the ID/EX payload.
package id_pkg;

  localparam logic [4:0] OP_BR0   = 5'b01010;
  localparam logic [4:0] OP_BR1   = 5'b01011;
  localparam logic [4:0] OP_BR2   = 5'b01100;
  localparam logic [4:0] OP_LOAD  = 5'b01101;
  localparam logic [4:0] OP_STORE = 5'b01110;
  localparam logic [4:0] OP_FFT   = 5'b11000;
  localparam logic [4:0] OP_CRY0  = 5'b11001;
  localparam logic [4:0] OP_CRY1  = 5'b11010;

  // Weakly taken, so a cold predictor behaves like the old static policy.
  localparam logic [1:0] BHT_RST = 2'b10;

  typedef struct packed {
    logic [4:0] opcode;
    logic       mem_read;
    logic       mem_write;
    logic       fft;
    logic       crypto;
    logic       branch;
    logic [1:0] prediction;
  } id_ctrl_t;

  function automatic id_ctrl_t decode_ctrl(input logic [4:0] op, input logic [1:0] ctr);
    id_ctrl_t c;
    c            = '0;
    c.opcode     = op;
    c.mem_read   = (op == OP_LOAD);
    c.mem_write  = (op == OP_STORE);
    c.fft        = (op == OP_FFT);
    c.crypto     = (op == OP_CRY0) || (op == OP_CRY1);
    c.branch     = (op == OP_BR0) || (op == OP_BR1) || (op == OP_BR2);
    c.prediction = c.branch ? ctr : 2'b00;
    return c;
  endfunction

endpackage

// File: rtl/id_bht.sv
// Branch history table of 2-bit saturating counters; the lookup is a plain
// array read so a same-cycle update is only visible from the next cycle.
module id_bht
  import id_pkg::*;
#(
  parameter  int BHT_DEPTH = 16,
  localparam int BI        = $clog2(BHT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BI-1:0] lkp_idx_i,
  output logic [1:0]    lkp_ctr_o,
  input  logic          upd_valid_i,
  input  logic [BI-1:0] upd_idx_i,
  input  logic          upd_taken_i
);

  logic [1:0] ctr_q [BHT_DEPTH];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= BHT_RST;
    end else if (upd_valid_i) begin
      ctr_q[upd_idx_i] <= sat_step(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign lkp_ctr_o = ctr_q[lkp_idx_i];

endmodule

// File: rtl/id_stage_p.sv
// Instruction decode: register file with write-back bypass, load-use hazard
// detection, dynamic branch prediction and the ID/EX pipeline register.
module id_stage_p
  import id_pkg::*;
#(
  parameter  int XLEN      = 19,
  parameter  int NREG      = 8,
  parameter  int IMM_W     = 15,
  parameter  int BHT_DEPTH = 16,
  localparam int RA        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [RA-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            br_upd_valid,
  input  logic [XLEN-1:0] br_upd_pc,
  input  logic            br_upd_taken,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [4:0]      ex_opcode,
  output logic [RA-1:0]   ex_rd,
  output logic [RA-1:0]   ex_rs1,
  output logic [RA-1:0]   ex_rs2,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_fft,
  output logic            ex_crypto,
  output logic            ex_branch,
  output logic [1:0]      ex_prediction
);

  localparam int BI = $clog2(BHT_DEPTH);

  function automatic logic signed [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] f);
    return $signed({{(XLEN-IMM_W){f[IMM_W-1]}}, f});
  endfunction

  logic [4:0]             if_op;
  logic [RA-1:0]          if_rd, if_rs1, if_rs2;
  logic [XLEN-1:0]        rs1_data_d, rs2_data_d;
  logic signed [XLEN-1:0] imm_d;
  logic [1:0]             bht_ctr;
  id_ctrl_t               ctrl_d;
  logic                   hazard, advance, accept, valid_d;

  logic [XLEN-1:0]        rf_q [NREG];
  logic                   valid_q;
  id_ctrl_t               ctrl_q;
  logic [RA-1:0]          rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]        rs1_data_q, rs2_data_q, pc_q;
  logic signed [XLEN-1:0] imm_q;

  // Only the index bits of the resolved PC select a counter.
  logic unused_upd_pc_hi;
  assign unused_upd_pc_hi = ^br_upd_pc[XLEN-1:BI];

  // ---- decode (combinational, IF -> ID) ----
  assign if_op  = if_instr[XLEN-1 -: 5];
  assign if_rd  = if_instr[XLEN-6 -: RA];
  assign if_rs1 = if_instr[XLEN-6-RA -: RA];
  assign if_rs2 = if_instr[XLEN-6-2*RA -: RA];
  assign imm_d  = sext_imm(if_instr[IMM_W-1:0]);

  // A write-back in the decode cycle wins over the stored register value.
  assign rs1_data_d = (wb_we && wb_rd == if_rs1) ? wb_data : rf_q[if_rs1];
  assign rs2_data_d = (wb_we && wb_rd == if_rs2) ? wb_data : rf_q[if_rs2];

  id_bht #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .lkp_idx_i   (if_pc[BI-1:0]),
    .lkp_ctr_o   (bht_ctr),
    .upd_valid_i (br_upd_valid),
    .upd_idx_i   (br_upd_pc[BI-1:0]),
    .upd_taken_i (br_upd_taken)
  );

  assign ctrl_d = decode_ctrl(if_op, bht_ctr);

  assign hazard   = if_valid & valid_q & ctrl_q.mem_read &
                    ((rd_q == if_rs1) | (rd_q == if_rs2));
  assign advance  = ~valid_q | ex_ready;
  assign id_ready = rst & ~flush & ~hazard & advance;
  assign accept   = if_valid & id_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)        valid_d = 1'b0;
    else if (advance) valid_d = accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // ---- ID/EX register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        ctrl_q     <= ctrl_d;
        rd_q       <= if_rd;
        rs1_q      <= if_rs1;
        rs2_q      <= if_rs2;
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
        imm_q      <= imm_d;
        pc_q       <= if_pc;
      end
    end
  end

  assign ex_valid      = valid_q;
  assign ex_opcode     = ctrl_q.opcode;
  assign ex_rd         = rd_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_fft        = ctrl_q.fft;
  assign ex_crypto     = ctrl_q.crypto;
  assign ex_branch     = ctrl_q.branch;
  assign ex_prediction = ctrl_q.prediction;

endmodule

// File: tb/tb_id_stage_p.sv
// Randomised and directed bench for id_stage_p against a cycle-level
// behavioural model of the decode stage.
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [18:0] if_instr, if_pc;
  logic        id_ready;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [18:0] wb_data;
  logic        flush;
  logic        br_upd_valid;
  logic [18:0] br_upd_pc;
  logic        br_upd_taken;
  logic        ex_ready;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_rd, ex_rs1, ex_rs2;
  logic [18:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic        ex_mem_read, ex_mem_write, ex_fft, ex_crypto, ex_branch;
  logic [1:0]  ex_prediction;

  int checks = 0;
  int errors = 0;

  // Model state: what the ID/EX register, register file and predictor hold.
  int m_valid, m_op, m_rd, m_rs1, m_rs2, m_d1, m_d2, m_imm, m_pc, m_pred;
  int m_rf[8];
  int m_bht[16];

  id_stage_p dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc),
    .br_upd_taken(br_upd_taken), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_fft(ex_fft), .ex_crypto(ex_crypto), .ex_branch(ex_branch),
    .ex_prediction(ex_prediction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_pred = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    for (int i = 0; i < 16; i++) m_bht[i] = 2;
  endtask

  task automatic idle();
    if_valid = 0; if_instr = '0; if_pc = '0; flush = 0; ex_ready = 1;
    wb_we = 0; wb_rd = '0; wb_data = '0;
    br_upd_valid = 0; br_upd_pc = '0; br_upd_taken = 0;
  endtask

  task automatic check_ex();
    chk("ex_valid", int'(ex_valid), m_valid);
    chk("ex_opcode", int'(ex_opcode), m_op);
    chk("ex_rd", int'(ex_rd), m_rd);
    chk("ex_rs1", int'(ex_rs1), m_rs1);
    chk("ex_rs2", int'(ex_rs2), m_rs2);
    chk("ex_rs1_data", int'(ex_rs1_data), m_d1);
    chk("ex_rs2_data", int'(ex_rs2_data), m_d2);
    chk("ex_imm", int'(ex_imm), m_imm);
    chk("ex_pc", int'(ex_pc), m_pc);
    chk("ex_mem_read", int'(ex_mem_read), int'(m_op == 13));
    chk("ex_mem_write", int'(ex_mem_write), int'(m_op == 14));
    chk("ex_fft", int'(ex_fft), int'(m_op == 24));
    chk("ex_crypto", int'(ex_crypto), int'(m_op == 25 || m_op == 26));
    chk("ex_branch", int'(ex_branch), int'(m_op >= 10 && m_op <= 12));
    chk("ex_prediction", int'(ex_prediction), m_pred);
  endtask

  // One clock cycle: inputs already driven after the falling edge.
  task automatic tick();
    int ins, op, rd, rs1, rs2, hz, rdy, idx;
    #1;
    ins = int'(if_instr);
    op  = ins / 16384;
    rd  = (ins / 2048) % 8;
    rs1 = (ins / 256) % 8;
    rs2 = (ins / 32) % 8;
    hz  = (if_valid && m_valid && m_op == 13 && (m_rd == rs1 || m_rd == rs2)) ? 1 : 0;
    rdy = (!flush && !hz && (!m_valid || ex_ready)) ? 1 : 0;
    chk("id_ready", int'(id_ready), rdy);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (!m_valid || ex_ready) begin
      if (if_valid && rdy) begin
        m_valid = 1; m_op = op; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2;
        m_d1 = (wb_we && int'(wb_rd) == rs1) ? int'(wb_data) : m_rf[rs1];
        m_d2 = (wb_we && int'(wb_rd) == rs2) ? int'(wb_data) : m_rf[rs2];
        m_imm = ins % 32768;
        if (m_imm >= 16384) m_imm += 524288 - 32768;
        m_pc = int'(if_pc);
        m_pred = (op >= 10 && op <= 12) ? m_bht[int'(if_pc) % 16] : 0;
      end else m_valid = 0;
    end
    if (wb_we) m_rf[wb_rd] = int'(wb_data);
    if (br_upd_valid) begin
      idx = int'(br_upd_pc) % 16;
      if (br_upd_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else              m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    #1;
    check_ex();
    @(negedge clk);
  endtask

  function automatic logic [18:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int lo);
    return 19'(op * 16384 + rd * 2048 + rs1 * 256 + rs2 * 32 + lo);
  endfunction

  initial begin
    int ops[10];
    int saved_pc;
    ops = '{10, 11, 12, 13, 13, 14, 24, 25, 26, 1};
    idle();
    rst = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_id_ready", int'(id_ready), 0);
    chk("reset_ex_valid", int'(ex_valid), 0);
    chk("reset_ex_pc", int'(ex_pc), 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("post_reset_id_ready", int'(id_ready), 1);

    // First branch after reset sees the weakly-taken counter.
    if_valid = 1; if_instr = mk(10, 0, 0, 0, 0); if_pc = 19'h4;
    tick();
    chk("first_branch_pred", int'(ex_prediction), 2);

    // Decode of a load reading r2.
    idle(); wb_we = 1; wb_rd = 3'd2; wb_data = 19'h00123;
    tick();
    idle(); if_valid = 1; if_instr = 19'h34A00; if_pc = 19'h4;
    tick();
    chk("dec_mem_read", int'(ex_mem_read), 1);
    chk("dec_rd", int'(ex_rd), 1);
    chk("dec_rs1_data", int'(ex_rs1_data), 'h123);
    chk("dec_imm", int'(ex_imm), 'h7CA00);

    // Load-use: load r3 then an instruction reading r3.
    if_instr = mk(13, 3, 0, 0, 0); if_pc = 19'h8;
    tick();
    if_instr = mk(1, 4, 3, 0, 0); if_pc = 19'hC;
    #1;
    chk("lu_stall_ready", int'(id_ready), 0);
    tick();
    chk("lu_bubble", int'(ex_valid), 0);
    chk("lu_ready_after", int'(id_ready), 1);
    tick();
    chk("lu_issue_valid", int'(ex_valid), 1);
    chk("lu_issue_pc", int'(ex_pc), 'hC);

    // Write-back bypass into the decode cycle.
    if_instr = mk(1, 0, 5, 0, 0); if_pc = 19'h10;
    wb_we = 1; wb_rd = 3'd5; wb_data = 19'h1ABCD;
    tick();
    chk("bypass_rs1", int'(ex_rs1_data), 'h1ABCD);

    // Predictor saturation at index 8.
    idle(); br_upd_valid = 1; br_upd_pc = 19'h8; br_upd_taken = 1;
    repeat (3) tick();
    idle(); if_valid = 1; if_instr = mk(11, 0, 0, 0, 0); if_pc = 19'h8;
    tick();
    chk("bht_sat_hi", int'(ex_prediction), 3);
    idle(); br_upd_valid = 1; br_upd_pc = 19'h8; br_upd_taken = 0;
    repeat (4) tick();
    idle(); if_valid = 1; if_instr = mk(12, 0, 0, 0, 0); if_pc = 19'h18;
    tick();
    chk("bht_sat_lo", int'(ex_prediction), 0);

    // Backpressure then flush.
    if_instr = mk(24, 2, 1, 1, 7); if_pc = 19'h20;
    tick();
    saved_pc = int'(ex_pc);
    if_instr = mk(25, 2, 1, 1, 7); if_pc = 19'h24; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", int'(id_ready), 0);
      chk("bp_pc_hold", int'(ex_pc), saved_pc);
    end
    ex_ready = 1; flush = 1;
    tick();
    chk("flush_valid", int'(ex_valid), 0);
    flush = 0; if_valid = 0;
    tick();
    chk("flush_dropped", int'(ex_valid), 0);

    // Reset arriving in the middle of a load-use stall.
    idle(); if_valid = 1; if_instr = mk(13, 6, 0, 0, 0); if_pc = 19'h30;
    tick();
    if_instr = mk(1, 0, 0, 6, 0); if_pc = 19'h34; ex_ready = 0;
    tick();
    rst = 0;
    #1;
    chk("mid_rst_valid", int'(ex_valid), 0);
    chk("mid_rst_ready", int'(id_ready), 0);
    chk("mid_rst_rd", int'(ex_rd), 0);
    model_reset();
    @(negedge clk);
    idle(); rst = 1;
    tick();

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      if_valid     = ($urandom_range(99) < 75);
      if_instr     = mk(ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3),
                        $urandom_range(3), $urandom_range(255));
      if ($urandom_range(3) == 0) if_instr = 19'($urandom);
      if_pc        = 19'($urandom);
      flush        = ($urandom_range(99) < 8);
      ex_ready     = ($urandom_range(99) < 70);
      wb_we        = ($urandom_range(99) < 40);
      wb_rd        = 3'($urandom_range(7));
      wb_data      = 19'($urandom);
      br_upd_valid = ($urandom_range(99) < 30);
      br_upd_pc    = 19'($urandom);
      br_upd_taken = 1'($urandom_range(1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
